// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store_ram block.
//   - state_e     : controller state (SWEEP clears the array, IDLE serves
//                   single-address Load/Clear requests)
//   - DEF_DATA_W  : default entry width
//   - DEF_ADDR_W  : default address width (DEPTH = 2**ADDR_W)
//   - is_nonzero  : helper used when tracking the nonzero-entry count
// -----------------------------------------------------------------------------
package store_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Reduction-OR on a 32-bit view so one helper serves any DATA_W up to 32.
  function automatic logic is_nonzero(input logic [31:0] value);
    return |value;
  endfunction

endpackage

// File: rtl/store_mem.sv
// -----------------------------------------------------------------------------
// store_mem
// DEPTH x DATA_W storage array with one synchronous write port and one
// asynchronous read port. The asynchronous read lets the controller see the
// old contents of an entry in the same cycle it overwrites it, which the
// nonzero counter and the write-first readback both rely on.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read of mem[raddr]
// -----------------------------------------------------------------------------
module store_mem
  import store_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/store_ram.sv
// -----------------------------------------------------------------------------
// store_ram
// Switch-loaded read/write store with per-address Load/Clear, a sequenced
// whole-array clear (ClearAll or Reset), a registered readback for the LED
// bank and a live count of nonzero entries.
// Ports:
//   CLK       in   single clock, rising edge
//   Reset     in   synchronous active-high reset; starts a clear sweep
//   A         in   address (switches)
//   D         in   write data (switches)
//   Load      in   write D to Store[A] (level-sampled)
//   Clear     in   write 0 to Store[A] (level-sampled, loses to Load)
//   ClearAll  in   start a whole-array clear sweep (wins over Load/Clear)
//   LED       out  registered Store[A], write-first
//   Ao        out  registered A, aligned with LED
//   Busy      out  sweep in progress; requests ignored
//   Count     out  number of nonzero entries, 0..DEPTH
// -----------------------------------------------------------------------------
module store_ram
  import store_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic              Load,
  input  logic              Clear,
  input  logic              ClearAll,
  output logic [DATA_W-1:0] LED,
  output logic [ADDR_W-1:0] Ao,
  output logic              Busy,
  output logic [ADDR_W:0]   Count
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] led_q,   led_d;
  logic [ADDR_W-1:0] ao_q,    ao_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              old_nz;
  logic              new_nz;

  // The single read port always looks at A: it supplies the readback value
  // and the "old" value for the nonzero counter.
  store_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (A),
    .rdata (mem_rdata)
  );

  assign old_nz = is_nonzero(32'(mem_rdata));
  assign new_nz = is_nonzero(32'(mem_wdata));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    led_d     = '0;
    ao_d      = A;
    mem_we    = 1'b0;
    mem_waddr = A;
    mem_wdata = '0;

    unique case (state_q)
      SWEEP: begin
        // One entry per cycle; the pointer wraps back to 0 after the last
        // entry, which is harmless because a new sweep reloads it anyway.
        mem_we    = ~Reset;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + PTR_ONE;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        led_d = mem_rdata;
        if (ClearAll) begin
          state_d = SWEEP;
          ptr_d   = '0;
          count_d = '0;
        end else if (Load || Clear) begin
          mem_we    = ~Reset;
          mem_waddr = A;
          mem_wdata = Load ? D : '0;
          // Write-first: the LED shows the value being written this cycle.
          led_d     = mem_wdata;
          // Only zero <-> nonzero transitions move the count, so it can
          // never leave 0..DEPTH.
          if (!old_nz && new_nz) begin
            count_d = count_q + CNT_ONE;
          end else if (old_nz && !new_nz) begin
            count_d = count_q - CNT_ONE;
          end
        end
      end

      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      count_q <= '0;
      led_q   <= '0;
      ao_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      led_q   <= led_d;
      ao_q    <= ao_d;
    end
  end

  assign LED   = led_q;
  assign Ao    = ao_q;
  assign Busy  = (state_q == SWEEP);
  assign Count = count_q;

endmodule

// File: doc/store_ram.md
# store_ram

Parametrised successor to the switch-loaded 32×8 store. Provides a DATA_W × 2^ADDR_W read/write store with per-address Load/Clear, a sequenced whole-array clear (ClearAll and reset), a registered readback for the LED bank, and a live count of nonzero entries. Sits between the slide-switch/button inputs and the LED/address display.

## Interface
- DATA_W, 8, entry width (D, LED)
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries
- CLK  in  1  single clock, all logic rising-edge
- Reset  in  1  synchronous, active-high
- A  in  ADDR_W  address (switches)
- D  in  DATA_W  write data (switches)
- Load  in  1  write D to Store[A], level-sampled each cycle
- Clear  in  1  write 0 to Store[A], level-sampled
- ClearAll  in  1  start whole-array clear sweep
- LED  out  DATA_W  registered Store[A] readback
- Ao  out  ADDR_W  registered A, aligned with LED
- Busy  out  1  sweep in progress; Load/Clear/ClearAll ignored
- Count  out  ADDR_W+1  number of entries ≠ 0

## Operation
- FSM states: SWEEP, IDLE.
- Reset (any state): state←SWEEP, sweep pointer←0, Count←0, LED←0, Ao←0, Busy←1. Held Reset keeps pointer at 0.
- SWEEP: each cycle write 0 to Store[ptr], ptr←ptr+1; after ptr = DEPTH−1 is written, state←IDLE. Exactly DEPTH cycles. Load, Clear, ClearAll ignored. LED forced 0, Ao tracks A.
- IDLE, priority ClearAll > Load > Clear:
  - ClearAll: state←SWEEP, ptr←0, Count←0 next cycle; no write this cycle.
  - Load: Store[A]←D.
  - Clear: Store[A]←0.
- Count update on a single-address write, old value O=Store[A], new value N: O=0,N≠0 → +1; O≠0,N=0 → −1; otherwise unchanged. Load with D=0 behaves as Clear for counting. Range 0..DEPTH, never wraps.
- Readback: LED←(write to A this cycle ? written value : Store[A]) — write-first bypass; Ao←A.
- Reset mid-sweep restarts sweep at 0; ClearAll mid-sweep has no effect.

## Timing
- LED/Ao latency: 1 cycle from A change.
- Write visible on LED the cycle after the Load/Clear edge (bypass); Count updated same edge as write.
- Busy rises the edge ClearAll is accepted (or during Reset); falls on the edge that completes entry DEPTH−1; first Load accepted the cycle Busy is first 0.
- From Reset deassertion to Busy=0: DEPTH cycles.
- Array read for Count/bypass is combinational (distributed storage); no other combinational input→output paths.

## Structure
- Package store_pkg: state enum {SWEEP, IDLE}, default DATA_W/ADDR_W constants.
- One natural sub-module: store_mem — DEPTH×DATA_W array, one write port (we, waddr, wdata), one asynchronous read port; FSM, counter, and readback register stay in store_ram.

## Test plan
- Reset 1 cycle, then idle: Busy=1 for exactly 32 cycles, Count=0, LED=0 for every A swept 0..31.
- Load A=5, D=8'hA5: next cycle LED=8'hA5, Ao=5, Count=1; reload A=5 D=8'h3C → Count stays 1; Load A=5 D=0 → Count=0.
- Load and Clear both high at A=7, D=8'h11: Store[7]=8'h11 (Load wins), Count=1.
- Fill all 32 entries with nonzero values → Count=32; ClearAll → Busy 32 cycles, Count=0, all entries read 0; Load during sweep has no effect.
- Reset asserted at sweep cycle 10 for 2 cycles → sweep restarts, Busy=1 for 32 more cycles after deassertion.
- ClearAll and Load same IDLE cycle at A=3 D=8'hFF → no write, sweep starts, Store[3]=0 after sweep.
